// File: rtl/wavegen_pkg.sv
// ============================================================================
// wavegen_pkg : shared types and command-word layout for the DAC SPI path
// Rev 1.0
// ============================================================================
`default_nettype none

package wavegen_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FRAME     = 3'd1,
        S_GAP       = 3'd2,
        S_LDAC_WAIT = 3'd3,
        S_LDAC      = 3'd4
    } state_t;

    localparam int DAC_FRAME_BITS = 16;
    localparam int CH_BIT         = 15;
    localparam int GA_BIT         = 13;
    localparam int SHDN_BIT       = 12;

    // Bit 14 is a don't-care in the command word and is always sent as 0.
    function automatic logic [DAC_FRAME_BITS-1:0] build_frame(
        input logic        ch,
        input logic        ga_n,
        input logic [11:0] word
    );
        logic [DAC_FRAME_BITS-1:0] f;
        f           = '0;
        f[CH_BIT]   = ch;
        f[GA_BIT]   = ga_n;
        f[SHDN_BIT] = 1'b1;
        f[11:0]     = word;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_spi_tx_if.sv
// ============================================================================
// dac_spi_tx_if : sample-side inputs and SPI/status outputs of dac_spi_tx
// Rev 1.0
// ============================================================================
`default_nettype none

interface dac_spi_tx_if;

    logic        clk_sampling;
    logic        enableA;
    logic        enableB;
    logic [11:0] dacA_word;
    logic [11:0] dacB_word;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        dac_ldac_n;
    logic        busy;
    logic        overrun;

    modport master (
        output clk_sampling, enableA, enableB, dacA_word, dacB_word,
        input  spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, overrun
    );

    modport slave (
        input  clk_sampling, enableA, enableB, dacA_word, dacB_word,
        output spi_sclk, spi_mosi, spi_cs_n, dac_ldac_n, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/dac_spi_frame.sv
// ============================================================================
// dac_spi_frame : shifts one 16-bit SPI frame (mode 0, MSB first)
// Rev 1.0
// ============================================================================
`default_nettype none

module dac_spi_frame
    import wavegen_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [DAC_FRAME_BITS-1:0] i_data,
    output logic                      o_done,
    output logic                      o_sclk,
    output logic                      o_mosi,
    output logic                      o_cs_n
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       c_bit_last = 4'(DAC_FRAME_BITS - 1);

    logic                      r_active;
    logic                      r_high;
    logic                      r_tail;
    logic [DIV_W-1:0]          r_div;
    logic [3:0]                r_bit;
    logic [DAC_FRAME_BITS-1:0] r_shift;
    logic                      r_sclk;
    logic                      r_mosi;
    logic                      r_cs_n;
    logic                      w_div_end;

    assign w_div_end = (r_div == c_div_last);
    // Asserted in the last cs_n-low cycle so the sequencer can react on the same edge.
    assign o_done    = r_active & r_tail & w_div_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_high   <= 1'b0;
            r_tail   <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs_n   <= 1'b1;
        end else if (i_start && !r_active) begin
            r_active <= 1'b1;
            r_high   <= 1'b0;
            r_tail   <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= i_data << 1;
            r_sclk   <= 1'b0;
            r_mosi   <= i_data[DAC_FRAME_BITS-1];
            r_cs_n   <= 1'b0;
        end else if (r_active) begin
            if (w_div_end) begin
                r_div <= '0;
                if (r_tail) begin
                    r_active <= 1'b0;
                    r_tail   <= 1'b0;
                    r_cs_n   <= 1'b1;
                end else if (!r_high) begin
                    r_high <= 1'b1;
                    r_sclk <= 1'b1;
                end else begin
                    r_high <= 1'b0;
                    r_sclk <= 1'b0;
                    if (r_bit == c_bit_last) begin
                        r_tail <= 1'b1;
                        r_mosi <= 1'b0;
                    end else begin
                        r_bit   <= r_bit + 4'd1;
                        r_mosi  <= r_shift[DAC_FRAME_BITS-1];
                        r_shift <= r_shift << 1;
                    end
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_cs_n = r_cs_n;

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// dac_spi_tx : per-strobe A/B frame sequencing, LDAC pulse and overrun flag
// Rev 1.0
// ============================================================================
`default_nettype none

module dac_spi_tx
    import wavegen_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int LDAC_CYCLES = 2,
    parameter int GAIN_1X     = 1
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    localparam int               CNT_MAX     = (CLK_DIV > LDAC_CYCLES) ? CLK_DIV : LDAC_CYCLES;
    localparam int               CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_ldac_last = CNT_W'(LDAC_CYCLES - 1);
    localparam logic             c_ga_n      = (GAIN_1X != 0);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_ch;
    logic                      r_en_b;
    logic [11:0]               r_word_b;
    logic                      r_busy;
    logic                      r_ldac_n;
    logic                      r_overrun;
    logic                      w_accept;
    logic                      w_start;
    logic [DAC_FRAME_BITS-1:0] w_frame;
    logic                      w_done;

    dac_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_frame),
        .o_done  (w_done),
        .o_sclk  (bus.spi_sclk),
        .o_mosi  (bus.spi_mosi),
        .o_cs_n  (bus.spi_cs_n)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_frame     = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.clk_sampling && (bus.enableA || bus.enableB)) begin
                    // Frame is launched straight from the live inputs so cs_n falls one cycle after accept.
                    w_accept    = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = S_FRAME;
                    w_frame     = bus.enableA ? build_frame(1'b0, c_ga_n, bus.dacA_word)
                                              : build_frame(1'b1, c_ga_n, bus.dacB_word);
                end
            end
            S_FRAME: begin
                if (w_done) begin
                    w_state_nxt = (!r_ch && r_en_b) ? S_GAP : S_LDAC_WAIT;
                end
            end
            S_GAP: begin
                if (r_cnt == c_div_last) begin
                    w_start     = 1'b1;
                    w_frame     = build_frame(1'b1, c_ga_n, r_word_b);
                    w_state_nxt = S_FRAME;
                end
            end
            S_LDAC_WAIT: begin
                if (r_cnt == c_div_last) begin
                    w_state_nxt = S_LDAC;
                end
            end
            S_LDAC: begin
                if (r_cnt == c_ldac_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ch      <= 1'b0;
            r_en_b    <= 1'b0;
            r_word_b  <= '0;
            r_busy    <= 1'b0;
            r_ldac_n  <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_FRAME)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_accept) begin
                r_ch     <= !bus.enableA;
                r_en_b   <= bus.enableB;
                r_word_b <= bus.dacB_word;
            end else if ((r_state == S_GAP) && w_start) begin
                r_ch <= 1'b1;
            end

            // Status outputs track the next state so they stay registered yet cycle-aligned.
            r_busy    <= (w_state_nxt != S_IDLE);
            r_ldac_n  <= (w_state_nxt != S_LDAC);
            r_overrun <= bus.clk_sampling && (r_state != S_IDLE);
        end
    end

    assign bus.dac_ldac_n = r_ldac_n;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// tb_dac_spi_tx : scoreboard bench for dac_spi_tx (CLK_DIV=4 and CLK_DIV=1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dac_spi_tx;

    logic clk;
    logic rst;

    dac_spi_tx_if bus4 ();
    dac_spi_tx_if bus1 ();

    dac_spi_tx #(.CLK_DIV(4), .LDAC_CYCLES(2), .GAIN_1X(1)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    dac_spi_tx #(.CLK_DIV(1), .LDAC_CYCLES(2), .GAIN_1X(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int exp_ldac[2];
    int exp_ovr[2];
    int ldac_seen[2];
    int ovr_seen[2];

    // monitor state, one slot per DUT
    logic        prev_cs[2];
    logic        prev_sclk[2];
    logic        prev_ldac[2];
    logic        prev_busy[2];
    logic        prev_ovr[2];
    int          lo_run[2];
    int          hi_run[2];
    int          ldac_lo[2];
    int          rises[2];
    logic [15:0] shreg[2];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void push(int id, logic [15:0] v);
        if (id == 0) q0.push_back(v);
        else         q1.push_back(v);
    endfunction

    task automatic mon_step(input int id, input logic cs, input logic sclk, input logic mosi,
                            input logic ldac, input logic busy, input logic ovr, input logic rstv);
        int          d;
        int          qsz;
        logic [15:0] exp;
        d = (id == 0) ? 4 : 1;
        if (rstv) begin
            prev_cs[id]   = 1'b1;
            prev_sclk[id] = 1'b0;
            prev_ldac[id] = 1'b1;
            prev_busy[id] = 1'b0;
            prev_ovr[id]  = 1'b0;
            lo_run[id]    = 0;
            hi_run[id]    = 0;
            ldac_lo[id]   = 0;
            rises[id]     = 0;
            shreg[id]     = '0;
        end else begin
            if (!cs && prev_cs[id] && prev_busy[id])
                check("gap_cycles", 32'(hi_run[id]), 32'(d));
            if (cs && !prev_cs[id]) begin
                check("cs_low_cycles", 32'(lo_run[id]), 32'(33 * d));
                check("sclk_rises", 32'(rises[id]), 32'd16);
                qsz = (id == 0) ? q0.size() : q1.size();
                check("frame_expected", 32'(qsz > 0), 32'd1);
                if (qsz > 0) begin
                    exp = (id == 0) ? q0.pop_front() : q1.pop_front();
                    check("frame_bits", 32'(shreg[id]), 32'(exp));
                end
                rises[id] = 0;
            end
            if (sclk && !prev_sclk[id]) begin
                rises[id]++;
                shreg[id] = {shreg[id][14:0], mosi};
                check("sclk_inside_cs", 32'(cs), 32'd0);
            end
            if (cs && mosi) check("mosi_idle", 32'(mosi), 32'd0);
            if (!ldac && prev_ldac[id]) begin
                check("ldac_delay", 32'(hi_run[id]), 32'(d));
                ldac_seen[id]++;
            end
            if (ldac && !prev_ldac[id]) check("ldac_width", 32'(ldac_lo[id]), 32'd2);
            if (ovr) begin
                ovr_seen[id]++;
                check("overrun_width", 32'(prev_ovr[id]), 32'd0);
            end
            lo_run[id]    = cs ? 0 : lo_run[id] + 1;
            hi_run[id]    = cs ? hi_run[id] + 1 : 0;
            ldac_lo[id]   = ldac ? 0 : ldac_lo[id] + 1;
            prev_cs[id]   = cs;
            prev_sclk[id] = sclk;
            prev_ldac[id] = ldac;
            prev_busy[id] = busy;
            prev_ovr[id]  = ovr;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, bus4.spi_cs_n, bus4.spi_sclk, bus4.spi_mosi, bus4.dac_ldac_n,
                 bus4.busy, bus4.overrun, rst);
        mon_step(1, bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_mosi, bus1.dac_ldac_n,
                 bus1.busy, bus1.overrun, rst);
    end

    task automatic drive(input int id, input logic s, input logic ea, input logic eb,
                         input logic [11:0] wa, input logic [11:0] wb);
        if (id == 0) begin
            bus4.clk_sampling = s; bus4.enableA = ea; bus4.enableB = eb;
            bus4.dacA_word = wa;   bus4.dacB_word = wb;
        end else begin
            bus1.clk_sampling = s; bus1.enableA = ea; bus1.enableB = eb;
            bus1.dacA_word = wa;   bus1.dacB_word = wb;
        end
    endtask

    // One-cycle strobe; words are scrambled afterwards to prove they were latched.
    task automatic strobe(input int id, input logic ea, input logic eb,
                          input logic [11:0] wa, input logic [11:0] wb);
        drive(id, 1'b1, ea, eb, wa, wb);
        @(posedge clk);
        #1;
        drive(id, 1'b0, ea, eb, ~wa, ~wb);
    endtask

    task automatic wait_idle(input int id);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (((id == 0) ? bus4.busy : bus1.busy) == 1'b0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_state(input int id);
        if (id == 0) begin
            check("rst_cs_n4", 32'(bus4.spi_cs_n), 32'd1);
            check("rst_sclk4", 32'(bus4.spi_sclk), 32'd0);
            check("rst_mosi4", 32'(bus4.spi_mosi), 32'd0);
            check("rst_ldac4", 32'(bus4.dac_ldac_n), 32'd1);
            check("rst_busy4", 32'(bus4.busy), 32'd0);
            check("rst_ovr4",  32'(bus4.overrun), 32'd0);
        end else begin
            check("rst_cs_n1", 32'(bus1.spi_cs_n), 32'd1);
            check("rst_sclk1", 32'(bus1.spi_sclk), 32'd0);
            check("rst_mosi1", 32'(bus1.spi_mosi), 32'd0);
            check("rst_ldac1", 32'(bus1.dac_ldac_n), 32'd1);
            check("rst_busy1", 32'(bus1.busy), 32'd0);
            check("rst_ovr1",  32'(bus1.overrun), 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_ldac[i] = 0; exp_ovr[i] = 0; ldac_seen[i] = 0; ovr_seen[i] = 0;
        end
        drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        drive(1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 1: reset mid-idle
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state(0);
        check_reset_state(1);

        // 2: single channel A
        @(posedge clk); #1;
        strobe(0, 1'b1, 1'b0, 12'hABC, 12'h111);
        push(0, 16'h3ABC); exp_ldac[0]++;
        check("busy_after_accept", 32'(bus4.busy), 32'd1);
        wait_idle(0);
        repeat (5) @(posedge clk); #1;

        // 3: both channels, extreme codes
        strobe(0, 1'b1, 1'b1, 12'h000, 12'hFFF);
        push(0, 16'h3000); push(0, 16'hBFFF); exp_ldac[0]++;
        wait_idle(0);
        repeat (5) @(posedge clk); #1;

        // 4: strobe while busy
        strobe(0, 1'b1, 1'b0, 12'h123, 12'h000);
        push(0, 16'h3123); exp_ldac[0]++;
        repeat (49) @(posedge clk);
        #1 drive(0, 1'b1, 1'b1, 1'b1, 12'h456, 12'h789);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
        exp_ovr[0]++;
        @(negedge clk);
        check("overrun_pulse", 32'(bus4.overrun), 32'd1);
        @(negedge clk);
        check("overrun_clear", 32'(bus4.overrun), 32'd0);
        wait_idle(0);
        repeat (5) @(posedge clk); #1;

        // 5: reset mid-frame aborts without a latch pulse
        strobe(0, 1'b1, 1'b0, 12'h5A5, 12'h000);
        repeat (59) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_cs_n", 32'(bus4.spi_cs_n), 32'd1);
        check("abort_sclk", 32'(bus4.spi_sclk), 32'd0);
        check("abort_busy", 32'(bus4.busy), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_no_ldac", 32'(ldac_seen[0]), 32'(exp_ldac[0]));
        @(posedge clk); #1;
        strobe(0, 1'b1, 1'b0, 12'h777, 12'h000);
        push(0, 16'h3777); exp_ldac[0]++;
        wait_idle(0);

        // 6: CLK_DIV=1, empty strobe then channel B only
        @(posedge clk); #1;
        strobe(1, 1'b0, 1'b0, 12'h800, 12'h800);
        repeat (3) begin
            @(negedge clk);
            check("empty_strobe_busy", 32'(bus1.busy), 32'd0);
            check("empty_strobe_cs", 32'(bus1.spi_cs_n), 32'd1);
        end
        @(posedge clk); #1;
        strobe(1, 1'b0, 1'b1, 12'h000, 12'h800);
        push(1, 16'hB800); exp_ldac[1]++;
        wait_idle(1);
        // strobe in the very cycle busy drops is accepted
        strobe(1, 1'b1, 1'b1, 12'h001, 12'h7FE);
        push(1, 16'h3001); push(1, 16'hB7FE); exp_ldac[1]++;
        check("back_to_back_busy", 32'(bus1.busy), 32'd1);
        wait_idle(1);

        repeat (20) @(negedge clk);
        check("q4_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("ldac_count4", 32'(ldac_seen[0]), 32'(exp_ldac[0]));
        check("ldac_count1", 32'(ldac_seen[1]), 32'(exp_ldac[1]));
        check("ovr_count4", 32'(ovr_seen[0]), 32'(exp_ovr[0]));
        check("ovr_count1", 32'(ovr_seen[1]), 32'(exp_ovr[1]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
